dsmc_dram_pingpong_ctrl: RTL and testbench

- Write-side sequencer for dsmc_dram. Streams ADC samples into the RAM as two ping-pong banks, where the address MSB selects the bank.
- Flags each bank full to the DSMC host read side and raises an interrupt pulse.
- Waits for a host acknowledge before a bank is reused.
- Handles overrun by dropping samples and counting them.

---
 rtl/dsmc_dram_pingpong_ctrl.sv | 138 +++++++++++++
 tb/tb_dsmc_dram_pingpong_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsmc_dram_pingpong_ctrl.sv
// rtl/dsmc_dram_pingpong_ctrl.sv - ping-pong bank write sequencer for dsmc_dram
// Streams samples into two RAM banks (address MSB = bank), flags full banks to the host, counts overrun drops.
module dsmc_dram_pingpong_ctrl #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     sample_data,
    input  logic                      sample_valid,
    input  logic [1:0]                bank_ack,
    input  logic                      clear_ovf,
    output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
    output logic [DATA_WIDTH-1:0]     ram_wr_data,
    output logic                      ram_wr_en,
    output logic [1:0]                bank_full,
    output logic                      last_bank,
    output logic                      irq,
    output logic                      active,
    output logic [ADDR_WIDTH-2:0]     fill_level,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_FREE = 2'd2
    } state_t;

    state_t                state;
    logic                  enable_d;
    logic                  cur_bank;
    logic [ADDR_WIDTH-2:0] ptr;

    logic       accept;
    logic       drop;
    logic       complete;
    logic       next_bank_busy;
    logic [1:0] bank_full_acked;

    // WAIT_FREE resumes writing as soon as the host ack has become visible in bank_full.
    always_comb begin
        accept          = 1'b0;
        drop            = 1'b0;
        if (sample_valid) begin
            if (state == FILL) begin
                accept = 1'b1;
            end else if (state == WAIT_FREE) begin
                accept = !bank_full[cur_bank];
                drop   = bank_full[cur_bank];
            end
        end
        complete        = accept && enable && (ptr == '1);
        next_bank_busy  = bank_full[~cur_bank] && !bank_ack[~cur_bank];
        bank_full_acked = bank_full & ~bank_ack;
    end

    assign active     = (state != IDLE);
    assign fill_level = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            enable_d    <= 1'b0;
            cur_bank    <= 1'b0;
            ptr         <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            bank_full   <= 2'b00;
            last_bank   <= 1'b0;
            irq         <= 1'b0;
        end else begin
            enable_d  <= enable;
            ram_wr_en <= accept;
            irq       <= complete;
            if (accept) begin
                ram_wr_addr <= {cur_bank, ptr};
                ram_wr_data <= sample_data;
            end

            case (state)
                IDLE: begin
                    if (enable && !enable_d) begin
                        bank_full <= 2'b00;
                        cur_bank  <= 1'b0;
                        ptr       <= '0;
                        state     <= FILL;
                    end else begin
                        bank_full <= bank_full_acked;
                    end
                end
                FILL, WAIT_FREE: begin
                    bank_full <= bank_full_acked;
                    if (!enable) begin
                        // Partial bank is abandoned; flags stay so the host can drain.
                        ptr   <= '0;
                        state <= IDLE;
                    end else if (complete) begin
                        bank_full[cur_bank] <= 1'b1;
                        last_bank           <= cur_bank;
                        ptr                 <= '0;
                        cur_bank            <= ~cur_bank;
                        state               <= next_bank_busy ? WAIT_FREE : FILL;
                    end else begin
                        if (accept) begin
                            ptr <= ptr + 1'b1;
                        end
                        if (state == WAIT_FREE && !bank_full[cur_bank]) begin
                            state <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf leaves exactly that one drop recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
                drop_cnt <= {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_dsmc_dram_pingpong_ctrl.sv
// tb/tb_dsmc_dram_pingpong_ctrl.sv - self-checking bench for dsmc_dram_pingpong_ctrl
// Directed steps plus random traffic, compared every cycle against a bank-bookkeeping model.
module tb_dsmc_dram_pingpong_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic [1:0]    bank_ack = 2'b00;
    logic          clear_ovf = 1'b0;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_en;
    logic [1:0]    bank_full;
    logic          last_bank;
    logic          irq;
    logic          active;
    logic [AW-2:0] fill_level;
    logic          overflow;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    dsmc_dram_pingpong_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_data(sample_data),
        .sample_valid(sample_valid), .bank_ack(bank_ack), .clear_ovf(clear_ovf),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .bank_full(bank_full), .last_bank(last_bank), .irq(irq), .active(active),
        .fill_level(fill_level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference: capture running flag, bank/slot bookkeeping and expected registered outputs.
    bit            m_run, m_en_d, m_bank, m_last, m_ovf, m_irq, m_wr;
    int            m_ptr, m_cnt;
    bit [1:0]      m_full;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_run = 0; m_en_d = 0; m_bank = 0; m_last = 0; m_ovf = 0; m_irq = 0; m_wr = 0;
        m_ptr = 0; m_cnt = 0; m_full = 2'b00; m_addr = '0; m_data = '0;
    endtask

    task automatic model_step(input bit en, input bit v, input logic [DW-1:0] d,
                              input bit [1:0] ack, input bit clr);
        bit [1:0] nfull;
        bit       dropped;
        nfull   = m_full & ~ack;
        dropped = 0;
        m_wr    = 0;
        m_irq   = 0;
        if (m_run) begin
            if (v && m_full[m_bank]) begin
                dropped = 1;
            end else if (v) begin
                m_wr   = 1;
                m_addr = AW'(m_bank * DEPTH + m_ptr);
                m_data = d;
            end
            if (!en) begin
                m_run = 0;
                m_ptr = 0;
            end else if (m_wr) begin
                if (m_ptr == DEPTH - 1) begin
                    nfull[m_bank] = 1;
                    m_last = m_bank;
                    m_irq  = 1;
                    m_ptr  = 0;
                    m_bank = !m_bank;
                end else begin
                    m_ptr = m_ptr + 1;
                end
            end
        end else if (en && !m_en_d) begin
            nfull  = 2'b00;
            m_bank = 0;
            m_ptr  = 0;
            m_run  = 1;
        end
        m_full = nfull;
        m_en_d = en;
        if (dropped) begin
            m_ovf = 1;
            m_cnt = clr ? 1 : ((m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1);
        end else if (clr) begin
            m_ovf = 0;
            m_cnt = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ram_wr_en", 32'(ram_wr_en), 32'(m_wr));
        if (m_wr) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(m_addr));
            chk("ram_wr_data", ram_wr_data, m_data);
        end
        chk("irq", 32'(irq), 32'(m_irq));
        chk("bank_full", 32'(bank_full), 32'(m_full));
        chk("last_bank", 32'(last_bank), 32'(m_last));
        chk("active", 32'(active), 32'(m_run));
        chk("fill_level", 32'(fill_level), 32'(m_ptr));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    endtask

    task automatic step(input bit en, input bit v, input logic [DW-1:0] d,
                        input bit [1:0] ack, input bit clr);
        enable = en; sample_valid = v; sample_data = d; bank_ack = ack; clear_ovf = clr;
        model_step(en, v, d, ack, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_wr_en", 32'(ram_wr_en), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bank 0 fill, completion, rollover into bank 1.
        step(1, 0, '0, 2'b00, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 32'h100 + i, 2'b00, 0);
        chk("first_irq", 32'(irq), 32'd1);
        chk("first_bank_full", 32'(bank_full), 32'd1);
        chk("first_last_bank", 32'(last_bank), 32'd0);
        chk("first_fill_level", 32'(fill_level), 32'd0);
        step(1, 1, 32'h108, 2'b00, 0);
        chk("rollover_addr", 32'(ram_wr_addr), 32'd8);
        for (int i = 1; i < 8; i++) step(1, 1, 32'h108 + i, 2'b00, 0);
        chk("both_full", 32'(bank_full), 32'd3);

        // Overrun drops, then ack coincident with a sample.
        for (int i = 0; i < 5; i++) step(1, 1, 32'h200 + i, 2'b00, 0);
        chk("drop5_cnt", 32'(drop_cnt), 32'd5);
        chk("drop5_ovf", 32'(overflow), 32'd1);
        chk("drop5_wr_en", 32'(ram_wr_en), 32'd0);
        step(1, 1, 32'h300, 2'b01, 0);
        chk("ack_cycle_drop", 32'(drop_cnt), 32'd6);
        step(1, 1, 32'h301, 2'b00, 0);
        chk("resume_wr_en", 32'(ram_wr_en), 32'd1);
        chk("resume_addr", 32'(ram_wr_addr), 32'd0);

        // Finish bank 0, free bank 1, 3 samples into it, then disable and re-enable.
        for (int i = 0; i < 7; i++) step(1, 1, 32'h310 + i, 2'b00, 0);
        step(1, 0, '0, 2'b10, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 32'h400 + i, 2'b00, 0);
        step(0, 0, '0, 2'b00, 0);
        chk("disable_active", 32'(active), 32'd0);
        chk("disable_bank_full", 32'(bank_full), 32'd1);
        step(0, 1, 32'h4ff, 2'b00, 0);
        step(1, 0, '0, 2'b00, 0);
        chk("reenable_bank_full", 32'(bank_full), 32'd0);
        step(1, 1, 32'h500, 2'b00, 0);
        chk("reenable_addr", 32'(ram_wr_addr), 32'd0);

        // Saturation of the drop counter and clear coincident with a drop.
        for (int i = 1; i < 16; i++) step(1, 1, 32'h500 + i, 2'b00, 0);
        step(1, 0, '0, 2'b00, 1);
        chk("cleared_cnt", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 65534; i++) step(1, 1, $urandom, 2'b00, 0);
        chk("cnt_fffe", 32'(drop_cnt), 32'hfffe);
        for (int i = 0; i < 3; i++) step(1, 1, $urandom, 2'b00, 0);
        chk("cnt_sat", 32'(drop_cnt), 32'hffff);
        step(1, 1, 32'h600, 2'b00, 1);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        step(1, 0, '0, 2'b11, 0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom,
                 {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
                 $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset in the middle of a bank.
        step(0, 0, '0, 2'b00, 0);
        step(0, 0, '0, 2'b00, 0);
        step(1, 0, '0, 2'b00, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 32'h700 + i, 2'b00, 0);
        sample_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_fill", 32'(fill_level), 32'd0);
        check_all();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;
        step(0, 1, 32'h800, 2'b00, 0);
        step(1, 1, 32'h801, 2'b00, 0);
        step(1, 1, 32'h802, 2'b00, 0);
        chk("post_rst_addr", 32'(ram_wr_addr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
